// File: rtl/pe_xi_4_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_xi_4_if
//  Description : Data bundle of one absolute-difference processing element.
//                The master side drives the current pixels, neighbour
//                reference pixels and the selects. The slave side (the PE)
//                returns abs_out and the forwarded pixel registers.
//  Ports       : in_curr1/2, in_curr_enable, CB_select, abs_Control,
//                up/down_ref_adajecent_1/8, change_ref, ref_input_Control
//                (master -> slave); abs_out, next_pix1/2, ref_pix
//                (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface pe_xi_4_if #(
    parameter int PIXEL = 8
);
    logic [PIXEL-1:0] in_curr1;
    logic [PIXEL-1:0] in_curr2;
    logic             in_curr_enable;
    logic             CB_select;
    logic [1:0]       abs_Control;
    logic [PIXEL-1:0] up_ref_adajecent_1;
    logic [PIXEL-1:0] up_ref_adajecent_8;
    logic [PIXEL-1:0] down_ref_adajecent_1;
    logic [PIXEL-1:0] down_ref_adajecent_8;
    logic             change_ref;
    logic             ref_input_Control;
    logic [PIXEL-1:0] abs_out;
    logic [PIXEL-1:0] next_pix1;
    logic [PIXEL-1:0] next_pix2;
    logic [PIXEL-1:0] ref_pix;

    modport master (
        output in_curr1, in_curr2, in_curr_enable, CB_select, abs_Control,
               up_ref_adajecent_1, up_ref_adajecent_8,
               down_ref_adajecent_1, down_ref_adajecent_8,
               change_ref, ref_input_Control,
        input  abs_out, next_pix1, next_pix2, ref_pix
    );

    modport slave (
        input  in_curr1, in_curr2, in_curr_enable, CB_select, abs_Control,
               up_ref_adajecent_1, up_ref_adajecent_8,
               down_ref_adajecent_1, down_ref_adajecent_8,
               change_ref, ref_input_Control,
        output abs_out, next_pix1, next_pix2, ref_pix
    );
endinterface
`default_nettype wire

// File: rtl/pe_xi_4.sv
`default_nettype none
// ============================================================================
//  Module      : pe_xi_4
//  Description : Absolute-difference PE of the integer motion-estimation
//                array. Holds two ping-pong current pixels, one reference
//                pixel reloaded every cycle from an up/down neighbour at
//                stride 1 or 8, and a registered |current - reference| term.
//  Ports       : clk    - rising-edge clock
//                rst_n  - asynchronous reset, active HIGH despite the name
//                bus    - pe_xi_4_if slave modport (pixels, selects, outputs)
//  Revision    : 1.0  initial release
// ============================================================================
module pe_xi_4 #(
    parameter int PIXEL = 8
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    pe_xi_4_if.slave   bus
);

    localparam logic [1:0] c_abs_zero   = 2'b00;
    localparam logic [1:0] c_abs_active = 2'b01;
    localparam logic [1:0] c_abs_other  = 2'b10;

    logic [PIXEL-1:0] r_cur1;
    logic [PIXEL-1:0] r_cur2;
    logic [PIXEL-1:0] r_ref;
    logic [PIXEL-1:0] r_abs;

    logic [PIXEL-1:0] w_ref_sel;
    logic [PIXEL-1:0] w_pix_a;
    logic [PIXEL-1:0] w_pix_b;
    logic [PIXEL-1:0] w_abs_a;
    logic [PIXEL-1:0] w_abs_b;

    // Reference source: direction picks the neighbour, stride picks the tap.
    always_comb begin
        w_ref_sel = bus.up_ref_adajecent_1;
        case ({bus.change_ref, bus.ref_input_Control})
            2'b00:   w_ref_sel = bus.up_ref_adajecent_1;
            2'b01:   w_ref_sel = bus.up_ref_adajecent_8;
            2'b10:   w_ref_sel = bus.down_ref_adajecent_1;
            default: w_ref_sel = bus.down_ref_adajecent_8;
        endcase
    end

    // Active / other pixel of the ping-pong pair.
    assign w_pix_a = bus.CB_select ? r_cur1 : r_cur2;
    assign w_pix_b = bus.CB_select ? r_cur2 : r_cur1;

    // Subtracting the smaller from the larger keeps the magnitude within
    // PIXEL bits, so no sign handling or saturation is required.
    assign w_abs_a = (w_pix_a >= r_ref) ? (w_pix_a - r_ref) : (r_ref - w_pix_a);
    assign w_abs_b = (w_pix_b >= r_ref) ? (w_pix_b - r_ref) : (r_ref - w_pix_b);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_cur1 <= '0;
            r_cur2 <= '0;
            r_ref  <= '0;
            r_abs  <= '0;
        end else begin
            if (bus.in_curr_enable) begin
                r_cur1 <= bus.in_curr1;
                r_cur2 <= bus.in_curr2;
            end
            // The reference has no hold state: it reloads on every edge.
            r_ref <= w_ref_sel;
            // Operands come from the pre-edge registers, giving one edge of
            // lag behind any current or reference load on the same edge.
            case (bus.abs_Control)
                c_abs_zero:   r_abs <= '0;
                c_abs_active: r_abs <= w_abs_a;
                c_abs_other:  r_abs <= w_abs_b;
                default:      r_abs <= r_abs;
            endcase
        end
    end

    assign bus.next_pix1 = r_cur1;
    assign bus.next_pix2 = r_cur2;
    assign bus.ref_pix   = r_ref;
    assign bus.abs_out   = r_abs;

endmodule
`default_nettype wire

// File: tb/tb_pe_xi_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_xi_4
//  Description : Self-checking bench for pe_xi_4. A table of per-edge input
//                records with hand-computed expected outputs is applied one
//                record per clock; expectations go into a scoreboard queue
//                when the record is driven and are popped after the edge.
//                Hand-written sequences cover asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pe_xi_4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pe_xi_4_if #(.PIXEL(8)) bus ();

    pe_xi_4 #(.PIXEL(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c1;
        logic [7:0] c2;
        logic       en;
        logic       cb;
        logic [1:0] absc;
        logic       chg;
        logic       ric;
        logic [7:0] u1;
        logic [7:0] u8;
        logic [7:0] d1;
        logic [7:0] d8;
        logic [7:0] e_n1;
        logic [7:0] e_n2;
        logic [7:0] e_ref;
        logic [7:0] e_abs;
    } vec_t;

    typedef struct {
        logic [7:0] n1;
        logic [7:0] n2;
        logic [7:0] rf;
        logic [7:0] ab;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        @(negedge clk);
        bus.in_curr1             = v.c1;
        bus.in_curr2             = v.c2;
        bus.in_curr_enable       = v.en;
        bus.CB_select            = v.cb;
        bus.abs_Control          = v.absc;
        bus.change_ref           = v.chg;
        bus.ref_input_Control    = v.ric;
        bus.up_ref_adajecent_1   = v.u1;
        bus.up_ref_adajecent_8   = v.u8;
        bus.down_ref_adajecent_1 = v.d1;
        bus.down_ref_adajecent_8 = v.d8;
        e.n1 = v.e_n1;
        e.n2 = v.e_n2;
        e.rf = v.e_ref;
        e.ab = v.e_abs;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1 (vec %0d)", idx);
        end else begin
            got = sb.pop_front();
            check8($sformatf("vec%0d_next_pix1", idx), bus.next_pix1, got.n1);
            check8($sformatf("vec%0d_next_pix2", idx), bus.next_pix2, got.n2);
            check8($sformatf("vec%0d_ref_pix", idx),   bus.ref_pix,   got.rf);
            check8($sformatf("vec%0d_abs_out", idx),   bus.abs_out,   got.ab);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check8({tag, "_abs_out"},   bus.abs_out,   8'h00);
        check8({tag, "_next_pix1"}, bus.next_pix1, 8'h00);
        check8({tag, "_next_pix2"}, bus.next_pix2, 8'h00);
        check8({tag, "_ref_pix"},   bus.ref_pix,   8'h00);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Fields: c1 c2 en cb absc chg ric u1 u8 d1 d8 | n1 n2 ref abs
        // Current load; abs cleared.
        vecs.push_back('{8'h0F,8'h07,1'b1,1'b1,2'b00,1'b1,1'b0,8'h03,8'h04,8'h01,8'h02, 8'h0F,8'h07,8'h01,8'h00});
        // Hold with new inputs; |0F-01| using active = cur1.
        vecs.push_back('{8'hAA,8'hBB,1'b0,1'b1,2'b01,1'b1,1'b1,8'h03,8'h04,8'h01,8'h02, 8'h0F,8'h07,8'h02,8'h0E});
        // Active = cur2: |07-02|.
        vecs.push_back('{8'hAA,8'hBB,1'b0,1'b0,2'b01,1'b0,1'b0,8'h03,8'h04,8'h01,8'h02, 8'h0F,8'h07,8'h03,8'h05});
        // Other with cb=1 -> cur2: |07-03|.
        vecs.push_back('{8'hAA,8'hBB,1'b0,1'b1,2'b10,1'b0,1'b1,8'h03,8'h04,8'h01,8'h02, 8'h0F,8'h07,8'h04,8'h04});
        // Other with cb=0 -> cur1: |0F-04|.
        vecs.push_back('{8'hAA,8'hBB,1'b0,1'b0,2'b10,1'b1,1'b0,8'h03,8'h04,8'h01,8'h02, 8'h0F,8'h07,8'h01,8'h0B});
        // ref=01: cb=1 -> 0E, cb=0 -> 06, absc=10 cb=1 -> 06.
        vecs.push_back('{8'hAA,8'hBB,1'b0,1'b1,2'b01,1'b1,1'b0,8'h03,8'h04,8'h01,8'h02, 8'h0F,8'h07,8'h01,8'h0E});
        vecs.push_back('{8'hAA,8'hBB,1'b0,1'b0,2'b01,1'b1,1'b0,8'h03,8'h04,8'h01,8'h02, 8'h0F,8'h07,8'h01,8'h06});
        vecs.push_back('{8'hAA,8'hBB,1'b0,1'b1,2'b10,1'b1,1'b0,8'h03,8'h04,8'h01,8'h02, 8'h0F,8'h07,8'h01,8'h06});
        // Hold mode keeps 06; then zero mode.
        vecs.push_back('{8'hAA,8'hBB,1'b0,1'b1,2'b11,1'b0,1'b0,8'h03,8'h04,8'h01,8'h02, 8'h0F,8'h07,8'h03,8'h06});
        vecs.push_back('{8'hAA,8'hBB,1'b0,1'b1,2'b00,1'b0,1'b0,8'h03,8'h04,8'h01,8'h02, 8'h0F,8'h07,8'h03,8'h00});
        // Bounds: cur1=00, cur2=FF, ref=FF.
        vecs.push_back('{8'h00,8'hFF,1'b1,1'b1,2'b11,1'b0,1'b0,8'hFF,8'h04,8'h01,8'h02, 8'h00,8'hFF,8'hFF,8'h00});
        vecs.push_back('{8'h11,8'h22,1'b0,1'b1,2'b01,1'b0,1'b0,8'hFF,8'h04,8'h01,8'h02, 8'h00,8'hFF,8'hFF,8'hFF});
        vecs.push_back('{8'h11,8'h22,1'b0,1'b0,2'b01,1'b0,1'b0,8'h00,8'h04,8'h01,8'h02, 8'h00,8'hFF,8'h00,8'h00});
        vecs.push_back('{8'h11,8'h22,1'b0,1'b0,2'b01,1'b0,1'b0,8'h00,8'h04,8'h01,8'h02, 8'h00,8'hFF,8'h00,8'hFF});
        vecs.push_back('{8'h11,8'h22,1'b0,1'b1,2'b10,1'b0,1'b0,8'h00,8'h04,8'h01,8'h02, 8'h00,8'hFF,8'h00,8'hFF});
        vecs.push_back('{8'h11,8'h22,1'b0,1'b1,2'b00,1'b0,1'b0,8'h00,8'h04,8'h01,8'h02, 8'h00,8'hFF,8'h00,8'h00});
        // Pipeline: reload cur, then change ref source every edge.
        vecs.push_back('{8'h50,8'h30,1'b1,1'b1,2'b01,1'b0,1'b0,8'h03,8'h04,8'h01,8'h02, 8'h50,8'h30,8'h03,8'h00});
        vecs.push_back('{8'h00,8'h00,1'b0,1'b1,2'b01,1'b0,1'b1,8'h03,8'h04,8'h01,8'h02, 8'h50,8'h30,8'h04,8'h4D});
        vecs.push_back('{8'h00,8'h00,1'b0,1'b1,2'b01,1'b1,1'b0,8'h03,8'h04,8'h01,8'h02, 8'h50,8'h30,8'h01,8'h4C});
        vecs.push_back('{8'h00,8'h00,1'b0,1'b1,2'b01,1'b1,1'b1,8'h03,8'h04,8'h01,8'h02, 8'h50,8'h30,8'h02,8'h4F});
        vecs.push_back('{8'h00,8'h00,1'b0,1'b1,2'b01,1'b0,1'b0,8'h03,8'h04,8'h01,8'h02, 8'h50,8'h30,8'h03,8'h4E});

        // Power-on reset with all inputs driven.
        rst_n                    = 1'b1;
        bus.in_curr1             = 8'h00;
        bus.in_curr2             = 8'h00;
        bus.in_curr_enable       = 1'b0;
        bus.CB_select            = 1'b0;
        bus.abs_Control          = 2'b00;
        bus.change_ref           = 1'b0;
        bus.ref_input_Control    = 1'b0;
        bus.up_ref_adajecent_1   = 8'h00;
        bus.up_ref_adajecent_8   = 8'h00;
        bus.down_ref_adajecent_1 = 8'h00;
        bus.down_ref_adajecent_8 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);

        // Mid-cycle asynchronous reset: outputs are nonzero beforehand and
        // must clear with no clock edge in between.
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_all_zero("async_reset");
        // Reset held across an edge with loading inputs active.
        bus.in_curr_enable = 1'b1;
        bus.in_curr1       = 8'h77;
        bus.abs_Control    = 2'b01;
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check8("post_reset_next_pix1", bus.next_pix1, 8'h77);
        check8("post_reset_abs_out",   bus.abs_out,   8'h00);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
